inst_fetch: RTL and testbench

Instruction-fetch stage between the PC/redirect logic and the IF/ID register. Each cycle it presents the current PC to the instruction cache. On a hit it issues the instruction to decode. On a miss it fetches the word byte-by-byte over the shared 8-bit memory port, refills the cache and then issues the instruction. Branch/jump redirects from EX abort any fetch in progress.

---
 rtl/inst_fetch_pkg.sv | 17 +
 rtl/inst_fetch_byte_assembler.sv | 68 ++++++
 rtl/inst_fetch.sv | 158 +++++++++++++++
 tb/tb_inst_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

  typedef logic [31:0] inst_addr_bus_t;
  typedef logic [31:0] inst_bus_t;

  localparam inst_bus_t ZeroWord = 32'h0000_0000;

  // Bytes per instruction word on the 8-bit memory port.
  localparam int unsigned ByteCnt = 4;

  typedef enum logic [0:0] {
    StLookup,
    StFetch
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_byte_assembler.sv
// Issue/receive counters and little-endian word buffer for byte-wise refills.
module inst_fetch_byte_assembler
  import inst_fetch_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           rdy_i,
  input  logic           active_i,
  input  logic           clear_i,
  input  logic           mem_gnt_i,
  input  logic [7:0]     mem_data_i,
  output logic           mem_rd_o,
  output logic [2:0]     iss_o,
  output logic           done_o,
  output inst_bus_t      word_o
);

  logic [2:0] iss_q, iss_d;
  logic [2:0] rcv_q, rcv_d;
  logic       pend_q, pend_d;
  inst_bus_t  word_q, word_d;

  // Request/capture bookkeeping; word_o already merges the byte arriving this cycle.
  always_comb begin
    mem_rd_o = active_i && rdy_i && (iss_q < 3'(ByteCnt));
    iss_o    = iss_q;
    word_o   = word_q;
    if (pend_q) begin
      word_o[{rcv_q[1:0], 3'b000} +: 8] = mem_data_i;
    end
    done_o = (rcv_q == 3'(ByteCnt)) || (pend_q && (rcv_q == 3'(ByteCnt - 1)));

    iss_d  = iss_q;
    rcv_d  = rcv_q;
    pend_d = pend_q;
    word_d = word_q;
    if (clear_i) begin
      iss_d  = '0;
      rcv_d  = '0;
      pend_d = 1'b0;
    end else begin
      if (mem_rd_o && mem_gnt_i) begin
        iss_d = iss_q + 3'd1;
      end
      pend_d = mem_rd_o && mem_gnt_i;
      if (pend_q) begin
        word_d = word_o;
        rcv_d  = rcv_q + 3'd1;
      end
    end
  end

  // Counter and buffer registers, frozen while rdy_i is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iss_q  <= '0;
      rcv_q  <= '0;
      pend_q <= 1'b0;
      word_q <= ZeroWord;
    end else if (rdy_i) begin
      iss_q  <= iss_d;
      rcv_q  <= rcv_d;
      pend_q <= pend_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: cache lookup, byte-wise refill on miss, redirect abort.
// Define FETCH_ICACHE_EN to use the instruction cache; otherwise every PC is fetched
// from memory and the refill write is never issued.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rdy_i,
  input  logic        jump_i,
  input  logic [31:0] jump_pc_i,
  input  logic        stall_i,
  output logic [31:0] ic_read_pc_o,
  input  logic        ic_hit_i,
  input  logic [31:0] ic_inst_i,
  output logic        ic_we_o,
  output logic [31:0] ic_write_pc_o,
  output logic [31:0] ic_write_inst_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  fetch_state_e   state_q, state_d;
  inst_addr_bus_t pc_q, pc_d;
  logic           valid_q, valid_d;
  inst_addr_bus_t if_pc_q, if_pc_d;
  inst_bus_t      if_inst_q, if_inst_d;
  logic           we_q, we_d;
  inst_addr_bus_t wpc_q, wpc_d;
  inst_bus_t      winst_q, winst_d;

  logic      hit;
  logic      accept;
  logic      asm_active;
  logic      asm_clear;
  logic      asm_done;
  logic [2:0] asm_iss;
  inst_bus_t asm_word;

`ifdef FETCH_ICACHE_EN
  assign hit     = ic_hit_i;
  assign ic_we_o = we_q && rdy_i;
`else
  logic unused_cache;
  assign hit          = 1'b0;
  assign ic_we_o      = 1'b0;
  assign unused_cache = ^{ic_hit_i, we_q};
`endif

  assign accept          = !valid_q || !stall_i;
  assign asm_active      = (state_q == StFetch) && !jump_i;
  assign ic_read_pc_o    = pc_q;
  assign mem_addr_o      = mem_rd_o ? (pc_q + {29'b0, asm_iss}) : ZeroWord;
  assign ic_write_pc_o   = wpc_q;
  assign ic_write_inst_o = winst_q;
  assign if_valid_o      = valid_q;
  assign if_pc_o         = if_pc_q;
  assign if_inst_o       = if_inst_q;

  inst_fetch_byte_assembler u_asm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rdy_i      (rdy_i),
    .active_i   (asm_active),
    .clear_i    (asm_clear),
    .mem_gnt_i  (mem_gnt_i),
    .mem_data_i (mem_data_i),
    .mem_rd_o   (mem_rd_o),
    .iss_o      (asm_iss),
    .done_o     (asm_done),
    .word_o     (asm_word)
  );

  // Next-state: redirect first, then lookup/refill sequencing gated by decode accept.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    we_d      = 1'b0;
    wpc_d     = wpc_q;
    winst_d   = winst_q;
    asm_clear = 1'b0;

    if (jump_i) begin
      pc_d      = jump_pc_i;
      valid_d   = 1'b0;
      state_d   = StLookup;
      asm_clear = 1'b1;
    end else begin
      case (state_q)
        StLookup: begin
          // Counters stay zeroed so a miss enters FETCH fresh.
          asm_clear = 1'b1;
          if (hit) begin
            if (accept) begin
              valid_d   = 1'b1;
              if_pc_d   = pc_q;
              if_inst_d = ic_inst_i;
              pc_d      = pc_q + 32'd4;
            end
          end else begin
            state_d = StFetch;
            if (accept) valid_d = 1'b0;
          end
        end
        StFetch: begin
          if (asm_done && accept) begin
            valid_d   = 1'b1;
            if_pc_d   = pc_q;
            if_inst_d = asm_word;
            we_d      = 1'b1;
            wpc_d     = pc_q;
            winst_d   = asm_word;
            pc_d      = pc_q + 32'd4;
            state_d   = StLookup;
            asm_clear = 1'b1;
          end else if (accept) begin
            valid_d = 1'b0;
          end
        end
        default: state_d = StLookup;
      endcase
    end
  end

  // State registers: synchronous reset, hold everything while rdy_i is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StLookup;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      if_pc_q   <= ZeroWord;
      if_inst_q <= ZeroWord;
      we_q      <= 1'b0;
      wpc_q     <= ZeroWord;
      winst_q   <= ZeroWord;
    end else if (rdy_i) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
      we_q      <= we_d;
      wpc_q     <= wpc_d;
      winst_q   <= winst_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch with byte memory and small cache models.
module tb_inst_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i, rdy_i, jump_i, stall_i;
  logic [31:0] jump_pc_i;
  logic [31:0] ic_read_pc_o, ic_inst_i, ic_write_pc_o, ic_write_inst_o;
  logic        ic_hit_i, ic_we_o;
  logic        mem_rd_o, mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i = 8'h00;
  logic        if_valid_o;
  logic [31:0] if_pc_o, if_inst_o;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          we_cnt = 0;
  int          we0;
  logic        gnt_mode = 1'b0;
  logic [31:0] cyc = '0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk_i = ~clk_i;

  inst_fetch #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rdy_i           (rdy_i),
    .jump_i          (jump_i),
    .jump_pc_i       (jump_pc_i),
    .stall_i         (stall_i),
    .ic_read_pc_o    (ic_read_pc_o),
    .ic_hit_i        (ic_hit_i),
    .ic_inst_i       (ic_inst_i),
    .ic_we_o         (ic_we_o),
    .ic_write_pc_o   (ic_write_pc_o),
    .ic_write_inst_o (ic_write_inst_o),
    .mem_rd_o        (mem_rd_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_data_i      (mem_data_i),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0100: return 32'hDEAD_BEEF;
      default:       return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = word_at({a[31:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Byte memory: data one cycle after a grant, frozen with rdy_i.
  assign mem_gnt_i = gnt_mode ? cyc[0] : 1'b1;
  always @(posedge clk_i) begin
    cyc <= cyc + 32'd1;
    if (rdy_i && mem_rd_o && mem_gnt_i) mem_data_i <= byte_at(mem_addr_o);
  end

  // Direct-mapped cache model with write-forward.
  logic        c_v[64];
  logic [31:0] c_tag[64];
  logic [31:0] c_dat[64];
  always_comb begin
    if (ic_we_o && (ic_write_pc_o == ic_read_pc_o)) begin
      ic_hit_i  = 1'b1;
      ic_inst_i = ic_write_inst_o;
    end else begin
      ic_hit_i  = c_v[ic_read_pc_o[7:2]] && (c_tag[ic_read_pc_o[7:2]] == ic_read_pc_o);
      ic_inst_i = c_dat[ic_read_pc_o[7:2]];
    end
  end
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 64; i++) c_v[i] <= 1'b0;
    end else if (ic_we_o) begin
      c_v[ic_write_pc_o[7:2]]   <= 1'b1;
      c_tag[ic_write_pc_o[7:2]] <= ic_write_pc_o;
      c_dat[ic_write_pc_o[7:2]] <= ic_write_inst_o;
    end
  end

  // Every refill write must carry the memory word for its PC.
  always @(negedge clk_i) begin
    if (!rst_i && ic_we_o) begin
      we_cnt++;
      check("we_inst", ic_write_inst_o, word_at(ic_write_pc_o));
    end
  end

  // Accept n instructions from decode, comparing each against the queued expectation.
  task automatic take(input int n, input logic [31:0] first_pc);
    int   taken = 0;
    int   budget = 0;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: first_pc + 32'(4 * i), inst: word_at(first_pc + 32'(4 * i))});
    end
    while (taken < n && budget < 40 * n) begin
      if (if_valid_o) begin
        e = exp_q.pop_front();
        check("issue_pc", if_pc_o, e.pc);
        check("issue_inst", if_inst_o, e.inst);
        taken++;
      end
      stall_i = 1'b0;
      @(negedge clk_i);
      budget++;
    end
    stall_i = 1'b1;
    if (taken < n) begin
      check("take_timeout", 32'(taken), 32'(n));
      exp_q.delete();
    end
  endtask

  task automatic wait_valid();
    int b = 0;
    while (!if_valid_o && b < 60) begin
      @(negedge clk_i);
      b++;
    end
    check("wait_valid", {31'b0, if_valid_o}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_i     = 1'b1;
    rdy_i     = 1'b1;
    jump_i    = 1'b0;
    jump_pc_i = '0;
    stall_i   = 1'b1;
    repeat (3) @(negedge clk_i);

    check("rst_valid", {31'b0, if_valid_o}, 32'd0);
    check("rst_pc", if_pc_o, 32'd0);
    check("rst_inst", if_inst_o, 32'd0);
    check("rst_we", {31'b0, ic_we_o}, 32'd0);
    check("rst_rd", {31'b0, mem_rd_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_read_pc", ic_read_pc_o, 32'd0);

    // Cold miss at RESET_PC: cycle 0 lookup, addresses 1..4, issue at 6.
    rst_i = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k >= 1 && k <= 4) begin
        check("miss_rd", {31'b0, mem_rd_o}, 32'd1);
        check("miss_addr", mem_addr_o, 32'(k - 1));
      end
      if (k == 5) check("miss_early", {31'b0, if_valid_o}, 32'd0);
      if (k == 6) begin
        check("miss_valid", {31'b0, if_valid_o}, 32'd1);
        check("miss_pc", if_pc_o, 32'd0);
        check("miss_inst", if_inst_o, 32'h0000_0013);
`ifdef FETCH_ICACHE_EN
        check("miss_we", {31'b0, ic_we_o}, 32'd1);
        check("miss_wpc", ic_write_pc_o, 32'd0);
`else
        check("miss_we", {31'b0, ic_we_o}, 32'd0);
`endif
      end
      if (k < 6) @(negedge clk_i);
    end
    take(4, 32'h0);

    // Stall with a valid instruction: outputs hold, then exactly one issue per accept.
    wait_valid();
    for (int k = 0; k < 3; k++) begin
      check("stall_pc", if_pc_o, 32'd16);
      check("stall_valid", {31'b0, if_valid_o}, 32'd1);
      @(negedge clk_i);
    end
    take(2, 32'd16);

    // Redirect back to the refilled loop.
    jump_i = 1'b1;
    jump_pc_i = 32'h0;
    @(negedge clk_i);
    jump_i = 1'b0;
`ifdef FETCH_ICACHE_EN
    check("hit_rd0", {31'b0, mem_rd_o}, 32'd0);
    check("hit_valid0", {31'b0, if_valid_o}, 32'd0);
    @(negedge clk_i);
    check("hit_valid", {31'b0, if_valid_o}, 32'd1);
    check("hit_pc", if_pc_o, 32'd0);
    check("hit_rd1", {31'b0, mem_rd_o}, 32'd0);
`endif
    take(3, 32'h0);

    // Abort a refill after two bytes have landed.
    jump_i = 1'b1;
    jump_pc_i = 32'h100;
    @(negedge clk_i);
    jump_i = 1'b0;
    @(negedge clk_i);
    we0 = we_cnt;
    repeat (3) @(negedge clk_i);
    jump_i = 1'b1;
    jump_pc_i = 32'h40;
    #1;
    check("abort_rd", {31'b0, mem_rd_o}, 32'd0);
    @(negedge clk_i);
    jump_i = 1'b0;
    @(negedge clk_i);
    check("abort_rd_new", {31'b0, mem_rd_o}, 32'd1);
    check("abort_addr", mem_addr_o, 32'h40);
    check("abort_no_we", 32'(we_cnt), 32'(we0));
    take(2, 32'h40);

    // Grant every other cycle: byte order preserved.
    gnt_mode = 1'b1;
    jump_i = 1'b1;
    jump_pc_i = 32'h100;
    @(negedge clk_i);
    jump_i = 1'b0;
    take(1, 32'h100);
    gnt_mode = 1'b0;

    // rdy_i low for two cycles mid-refill shifts the result by two cycles.
    jump_i = 1'b1;
    jump_pc_i = 32'h200;
    @(negedge clk_i);
    jump_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rdy_i = 1'b0;
    #1;
    check("frz_rd", {31'b0, mem_rd_o}, 32'd0);
    @(negedge clk_i);
    check("frz_pc", ic_read_pc_o, 32'h200);
    check("frz_rd2", {31'b0, mem_rd_o}, 32'd0);
    @(negedge clk_i);
    rdy_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("frz_early", {31'b0, if_valid_o}, 32'd0);
    @(negedge clk_i);
    check("frz_valid", {31'b0, if_valid_o}, 32'd1);
    check("frz_pc_out", if_pc_o, 32'h200);
    check("frz_inst", if_inst_o, word_at(32'h200));
    take(1, 32'h200);

`ifndef FETCH_ICACHE_EN
    check("no_we", 32'(we_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
